// File: rtl/seg7_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Reads back a multiplexed active-low 7-segment bus and rebuilds
//            the hex nibble shown on each digit once its pattern is stable.
// Revision : 1.0
// ============================================================================
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] hex_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic                    update_stb,
   output logic                    err_stb,
   output logic [2:0]              err_digit
);

   localparam int                    CW        = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]         C_STABLE  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0]         C_CNT_ONE = CW'(1);
   localparam logic [NUM_DIGITS-1:0] C_AN_ONE  = NUM_DIGITS'(1);
   localparam logic [6:0]            C_BLANK   = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [6:0]                seg_meta_q, s_seg_q, prev_seg_q;
   logic [NUM_DIGITS-1:0]     an_meta_q, s_an_q, prev_an_q;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0]   hex_q, hex_d;
   logic [NUM_DIGITS-1:0]     valid_q, valid_d;
   logic                      upd_q, upd_d;
   logic                      err_q, err_d;
   logic [2:0]                err_digit_q, err_digit_d;

   logic [NUM_DIGITS-1:0]     sel;
   logic                      one_hot;
   logic                      changed;
   logic                      capture;
   logic                      known;
   logic [3:0]                nib;
   logic [2:0]                dig;
   logic                      found;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_meta_q  <= '0;
         s_seg_q     <= '0;
         prev_seg_q  <= '0;
         an_meta_q   <= '0;
         s_an_q      <= '0;
         prev_an_q   <= '0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         hex_q       <= '0;
         valid_q     <= '0;
         upd_q       <= 1'b0;
         err_q       <= 1'b0;
         err_digit_q <= '0;
      end else begin
         seg_meta_q  <= seg_n;
         s_seg_q     <= seg_meta_q;
         prev_seg_q  <= s_seg_q;
         an_meta_q   <= an_n;
         s_an_q      <= an_meta_q;
         prev_an_q   <= s_an_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hex_q       <= hex_d;
         valid_q     <= valid_d;
         upd_q       <= upd_d;
         err_q       <= err_d;
         err_digit_q <= err_digit_d;
      end
   end

   // Exactly one anode low: sel is a power of two.
   always_comb begin
      sel     = ~s_an_q;
      one_hot = (sel != '0) && ((sel & (sel - C_AN_ONE)) == '0);
      changed = (s_seg_q != prev_seg_q) || (s_an_q != prev_an_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (one_hot) begin
               state_d = SETTLE;
               cnt_d   = C_CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         SETTLE, HELD: begin
            if (!changed) begin
               if (state_q == SETTLE && cnt_q != C_STABLE)
                  cnt_d = cnt_q + C_CNT_ONE;
            end else if (one_hot) begin
               state_d = SETTLE;
               cnt_d   = C_CNT_ONE;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Checked after the transition so a count of one captures immediately.
      if (state_d == SETTLE && cnt_d == C_STABLE) begin
         capture = 1'b1;
         state_d = HELD;
      end
   end

   always_comb begin
      known = 1'b1;
      nib   = 4'h0;
      case (s_seg_q)
         7'b1000000: nib = 4'h0;
         7'b1111001: nib = 4'h1;
         7'b0100100: nib = 4'h2;
         7'b0110000: nib = 4'h3;
         7'b0011001: nib = 4'h4;
         7'b0010010: nib = 4'h5;
         7'b0000010: nib = 4'h6;
         7'b1111000: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0011000: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b0000011: nib = 4'hB;
         7'b1000110: nib = 4'hC;
         7'b0100001: nib = 4'hD;
         7'b0000110: nib = 4'hE;
         7'b0001110: nib = 4'hF;
         default:    known = 1'b0;
      endcase
   end

   always_comb begin
      hex_d       = hex_q;
      valid_d     = valid_q;
      upd_d       = 1'b0;
      err_d       = 1'b0;
      err_digit_d = err_digit_q;
      dig         = '0;
      found       = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i] && !found) begin
            dig   = 3'(i);
            found = 1'b1;
         end
      end
      if (capture) begin
         if (known) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i]) begin
                  hex_d[4*i +: 4] = nib;
                  valid_d[i]      = 1'b1;
               end
            end
            upd_d = (hex_d != hex_q) || (valid_d != valid_q);
         end else if (s_seg_q == C_BLANK) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i])
                  valid_d[i] = 1'b0;
            end
            upd_d = (valid_d != valid_q);
         end else begin
            err_d       = 1'b1;
            err_digit_d = dig;
         end
      end
   end

   assign hex_out     = hex_q;
   assign digit_valid = valid_q;
   assign update_stb  = upd_q;
   assign err_stb     = err_q;
   assign err_digit   = err_digit_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Brief    : Randomised scoreboard bench for seg7_scan_decoder.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [6:0]      seg_n;
   logic [ND-1:0]   an_n;
   logic [4*ND-1:0] hex_out;
   logic [ND-1:0]   digit_valid;
   logic            update_stb;
   logic            err_stb;
   logic [2:0]      err_digit;

   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
      .hex_out(hex_out), .digit_valid(digit_valid), .update_stb(update_stb),
      .err_stb(err_stb), .err_digit(err_digit)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   logic [6:0] tbl [16];
   initial begin
      tbl[0]  = 7'b1000000; tbl[1]  = 7'b1111001; tbl[2]  = 7'b0100100; tbl[3]  = 7'b0110000;
      tbl[4]  = 7'b0011001; tbl[5]  = 7'b0010010; tbl[6]  = 7'b0000010; tbl[7]  = 7'b1111000;
      tbl[8]  = 7'b0000000; tbl[9]  = 7'b0011000; tbl[10] = 7'b0001000; tbl[11] = 7'b0000011;
      tbl[12] = 7'b1000110; tbl[13] = 7'b0100001; tbl[14] = 7'b0000110; tbl[15] = 7'b0001110;
   end

   typedef struct {
      bit              is_err;
      logic [4*ND-1:0] hex;
      logic [ND-1:0]   val;
      logic [2:0]      ed;
      int              at;
   } ev_t;

   ev_t             exp_q[$];
   logic [3:0]      m_nib [ND];
   logic [ND-1:0]   m_val;
   logic [2:0]      m_ed;
   logic [6+ND:0]   prev_pat;

   function automatic logic [4*ND-1:0] m_hex();
      logic [4*ND-1:0] h;
      for (int i = 0; i < ND; i++) h[4*i +: 4] = m_nib[i];
      return h;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
      m_val    = '0;
      m_ed     = '0;
      prev_pat = '0;
      exp_q.delete();
   endfunction

   function automatic int low_count(logic [ND-1:0] a);
      int c = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) c++;
      return c;
   endfunction

   // What the display shows after a stable capture, derived from the segment table.
   function automatic void model_capture(logic [6:0] s, logic [ND-1:0] a, int at);
      int  d = 0;
      int  v = -1;
      ev_t e;
      for (int i = ND - 1; i >= 0; i--) if (!a[i]) d = i;
      for (int k = 0; k < 16; k++) if (tbl[k] == s) v = k;
      e.is_err = 1'b0;
      e.at     = at;
      if (v >= 0) begin
         if (m_nib[d] != 4'(v) || !m_val[d]) begin
            m_nib[d] = 4'(v);
            m_val[d] = 1'b1;
            e.hex = m_hex(); e.val = m_val; e.ed = m_ed;
            exp_q.push_back(e);
         end
      end else if (s == 7'h7f) begin
         if (m_val[d]) begin
            m_val[d] = 1'b0;
            e.hex = m_hex(); e.val = m_val; e.ed = m_ed;
            exp_q.push_back(e);
         end
      end else begin
         m_ed     = 3'(d);
         e.is_err = 1'b1;
         e.hex = m_hex(); e.val = m_val; e.ed = m_ed;
         exp_q.push_back(e);
      end
   endfunction

   // Called at a negedge; pattern is sampled from the next posedge for n cycles.
   task automatic apply(input logic [6:0] s, input logic [ND-1:0] a, input int n);
      seg_n = s;
      an_n  = a;
      if (low_count(a) == 1 && n >= SC)
         model_capture(s, a, cyc + SC + 2);
      prev_pat = {s, a};
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (update_stb && err_stb)
            chk("both_strobes", 64'(update_stb & err_stb), 64'h0);
         if (update_stb || err_stb) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 64'({update_stb, err_stb}), 64'h0);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("strobe_kind", 64'({update_stb, err_stb}), e.is_err ? 64'h1 : 64'h2);
               chk("strobe_cycle", 64'(cyc), 64'(e.at));
               chk("hex_out", 64'(hex_out), 64'(e.hex));
               chk("digit_valid", 64'(digit_valid), 64'(e.val));
               if (e.is_err) chk("err_digit", 64'(err_digit), 64'(e.ed));
            end
         end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            ev_t e;
            e = exp_q.pop_front();
            chk("missed_strobe", 64'({update_stb, err_stb}), e.is_err ? 64'h1 : 64'h2);
         end
      end
   end

   initial begin
      logic [6:0]    s;
      logic [ND-1:0] a;
      int            n;
      rst_n = 1'b0;
      seg_n = 7'h7f;
      an_n  = '1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_hex", 64'(hex_out), 64'h0);
      chk("reset_valid", 64'(digit_valid), 64'h0);
      chk("reset_upd", 64'(update_stb), 64'h0);
      chk("reset_err", 64'(err_stb), 64'h0);
      chk("reset_errdig", 64'(err_digit), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset mid-settle discards the pending capture
      seg_n = tbl[11];
      an_n  = 4'b0111;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_hex", 64'(hex_out), 64'h0);
      chk("midrst_valid", 64'(digit_valid), 64'h0);
      chk("midrst_strobes", 64'({update_stb, err_stb}), 64'h0);
      model_reset();
      rst_n = 1'b1;
      apply(tbl[11], 4'b0111, SC + 6);

      // Single digit then scan sweeps
      apply(7'b0110000, 4'b1110, 20);
      for (int r = 0; r < 2; r++) begin
         apply(tbl[10], 4'b1110, 20);
         apply(tbl[11], 4'b1101, 20);
         apply(tbl[12], 4'b1011, 20);
         apply(tbl[13], 4'b0111, 20);
      end
      chk("sweep_hex", 64'(hex_out), 64'hDCBA);
      chk("sweep_valid", 64'(digit_valid), 64'hF);

      // Glitch rejection and two-anode rejection
      for (int g = 0; g < 6; g++) apply(g[0] ? tbl[5] : tbl[3], 4'b1011, 5);
      apply(tbl[8], 4'b0011, 20);
      chk("glitch_hex", 64'(hex_out), 64'hDCBA);

      // Unknown pattern then blank on digit 1
      apply(7'b1010101, 4'b1101, 20);
      apply(7'h7f, 4'b1101, 20);
      chk("blank_valid", 64'(digit_valid), 64'hD);

      // Randomised segments
      for (int k = 0; k < 300; k++) begin
         do begin
            n = int'($urandom_range(0, 9));
            if (n < 6)      s = tbl[$urandom_range(0, 15)];
            else if (n < 7) s = 7'h7f;
            else            s = 7'($urandom);
            if ($urandom_range(0, 9) < 8) a = ~(ND'(1) << $urandom_range(0, ND - 1));
            else                          a = ND'($urandom);
         end while ({s, a} == prev_pat);
         n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SC - 1))
                                         : int'($urandom_range(SC, SC + 12));
         apply(s, a, n);
      end

      apply(7'h7f, '1, SC + 6);
      chk("pending_events", 64'(exp_q.size()), 64'h0);
      chk("final_hex", 64'(hex_out), 64'(m_hex()));
      chk("final_valid", 64'(digit_valid), 64'(m_val));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
